data_mem_arbiter: RTL

- Shares the single data-memory port (8-bit address, 16-bit data, asynchronous read, synchronous write) between the processor and two secondary requesters: port 0 (serial loader) and port 1 (debug/DMA).
- The processor has no stall input, so it always wins the memory port.
- Secondary ports are served round-robin only in cycles where the processor is not accessing memory, using a req/ack handshake.
- The block sits between the processor's data-memory pins and the data RAM.

---
 rtl/data_mem_pkg.sv | 23 ++
 rtl/data_mem_arbiter_rr.sv | 40 ++++
 rtl/data_mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pkg
//  Description : Shared types and default widths for the data-memory arbiter
//                (secondary-path FSM encoding, address/data widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

  // Default data-memory geometry
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  // Secondary-path sequencer: take a request, wait for a free memory cycle,
  // then pulse the acknowledge for one cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } sec_state_t;

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-input round-robin pick. A single request wins outright;
//                when both request, the priority pointer decides. After a
//                port has been served the pointer moves to the other port.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic       grant_o
);

  // Priority pointer: index of the port that wins a tie
  logic rr_q;

  // Hand priority to the port that was not just served
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else if (update_i) begin
      rr_q <= ~served_i;
    end
  end

  // Grant index; with no request the value is irrelevant and follows rr
  always_comb begin
    case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      default: grant_o = rr_q;
    endcase
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Shares the single data-memory port between the processor
//                (always wins, zero latency, cannot stall) and two secondary
//                requesters served round-robin through a req/ack handshake
//                in cycles the processor leaves the memory idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CNT_W        = 6,
  // Must stay below 2**CNT_W so the saturating counter can reach it
  parameter int STARVE_LIMIT = 32
) (
  input  logic              clk,
  input  logic              reset,
  // Processor data-memory pins
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  // Secondary port 0 (serial loader)
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  // Secondary port 1 (debug/DMA)
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] sec_rdata,
  // Data RAM
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starve
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE_LIMIT);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  sec_state_t        state_q;
  logic              sel_q;
  logic              hold_we_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_wdata_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_d;
  logic              p0_ack_q;
  logic              p1_ack_q;
  logic [DATA_W-1:0] sec_rdata_q;

  logic              cpu_busy;
  logic              any_req;
  logic              grant;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  assign cpu_busy  = cpu_re | cpu_we;
  assign any_req   = p0_req | p1_req;
  assign cpu_rdata = mem_rdata;

  // --------------------------------------------------------------------------
  // Round-robin pick between the two secondary ports
  // --------------------------------------------------------------------------
  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req_i    ({p1_req, p0_req}),
    .update_i (state_q == ST_ACK),
    .served_i (sel_q),
    .grant_o  (grant)
  );

  // Request fields of the port that would be accepted this cycle
  always_comb begin
    req_we    = grant ? p1_we    : p0_we;
    req_addr  = grant ? p1_addr  : p0_addr;
    req_wdata = grant ? p1_wdata : p0_wdata;
  end

  // Saturating increment of the blocked-cycle counter
  always_comb begin
    wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
  end

  // Secondary sequencer with registered acks and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      wait_cnt_q   <= '0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      sec_rdata_q  <= '0;
    end else begin
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Requester inputs are only sampled here; they are frozen after
          if (any_req) begin
            sel_q        <= grant;
            hold_we_q    <= req_we;
            hold_addr_q  <= req_addr;
            hold_wdata_q <= req_wdata;
            state_q      <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (!cpu_busy) begin
            // Access cycle: the held request owns the memory port now
            if (!hold_we_q) begin
              sec_rdata_q <= mem_rdata;
            end
            p0_ack_q <= ~sel_q;
            p1_ack_q <= sel_q;
            state_q  <= ST_ACK;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        ST_ACK: begin
          wait_cnt_q <= '0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory port mux: processor first, then a PEND access cycle, else quiet
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (cpu_busy) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end else if (state_q == ST_PEND) begin
      mem_addr  = hold_addr_q;
      mem_we    = hold_we_q;
      mem_wdata = hold_wdata_q;
    end
    // No RAM writes of any origin while reset is held
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign sec_rdata = sec_rdata_q;
  assign starve    = (state_q == ST_PEND) && (wait_cnt_q >= STARVE_TH);

endmodule : data_mem_arbiter
`default_nettype wire
